// File: rtl/tri_digit_packer.sv
// Packs flagged 3-bit digits into DIGITS-wide words and buffers them in a ready/valid FIFO.
// Optional per-entry parity output is enabled by defining TRI_DIGIT_PACKER_PARITY_EN.
//
// state    | meaning
// ASSEMBLE | collecting digits into asm_q, idx_q counts digits held
// push     | combinational strobe on the edge a word completes or is flushed
module tri_digit_packer #(
  parameter int DIGITS     = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int W         = 3 * DIGITS,
  localparam int LEN_W     = $clog2(DIGITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_flag,
  input  logic [2:0]       in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [LEN_W-1:0] out_len,
  output logic             overflow
`ifdef TRI_DIGIT_PACKER_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     asm_q;
  logic [W-1:0]     word_d;
  logic [LEN_W-1:0] len_d;
  logic             last_digit;
  logic             push;

  logic [W-1:0]     mem_data [FIFO_DEPTH];
  logic [LEN_W-1:0] mem_len  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             pop;
  logic             accept;
  logic [W-1:0]     last_data_q;
  logic [LEN_W-1:0] last_len_q;

  // The incoming digit is merged before the push decision so flush+digit emits one word.
  always_comb begin
    word_d = asm_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (in_flag && (idx_q == IDX_W'(d))) begin
        word_d[3*d +: 3] = in_data;
      end
    end
    len_d      = LEN_W'(idx_q) + LEN_W'(in_flag);
    last_digit = in_flag && (idx_q == IDX_W'(DIGITS - 1));
    push       = last_digit || (flush && (in_flag || (idx_q != '0)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q <= '0;
      idx_q <= '0;
    end else if (push) begin
      asm_q <= '0;
      idx_q <= '0;
    end else if (in_flag) begin
      asm_q <= word_d;
      idx_q <= idx_q + IDX_W'(1);
    end
  end

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign accept    = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_data[wr_ptr] <= word_d;
      mem_len[wr_ptr]  <= len_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      last_data_q <= '0;
      last_len_q  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + PTR_W'(1);
        last_data_q <= mem_data[rd_ptr];
        last_len_q  <= mem_len[rd_ptr];
      end
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Once drained, the outputs keep showing the last word that was handed off.
  assign out_data = out_valid ? mem_data[rd_ptr] : last_data_q;
  assign out_len  = out_valid ? mem_len[rd_ptr]  : last_len_q;

`ifdef TRI_DIGIT_PACKER_PARITY_EN
  logic mem_par [FIFO_DEPTH];
  logic last_par_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_par[wr_ptr] <= ^word_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_par_q <= 1'b0;
    end else if (pop) begin
      last_par_q <= mem_par[rd_ptr];
    end
  end

  assign out_parity = out_valid ? mem_par[rd_ptr] : last_par_q;
`endif

endmodule

// File: tb/tb_tri_digit_packer.sv
// Scoreboard bench for tri_digit_packer: a queue-level reference model feeds an
// expected-word buffer that a negedge monitor drains on every handshake.
module tb_tri_digit_packer;
  localparam int DIGITS     = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int W          = 12;
  localparam int LEN_W      = 3;
  localparam int SB         = 1024;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_flag = 1'b0;
  logic [2:0]       in_data = 3'd0;
  logic             flush = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [LEN_W-1:0] out_len;
  logic             overflow;
`ifdef TRI_DIGIT_PACKER_PARITY_EN
  logic             out_parity;
`endif

  always #5 clk = ~clk;

  tri_digit_packer #(.DIGITS(DIGITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flag   (in_flag),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_len   (out_len),
    .overflow  (overflow)
`ifdef TRI_DIGIT_PACKER_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  // reference model state (written only by the model process)
  int           digs[$];
  int           mdl_cnt = 0;
  bit           exp_ovf = 1'b0;
  logic [W-1:0] exp_data [SB];
  int           exp_len  [SB];
  int           exp_wr = 0;

  // monitor state (written only by the monitor process)
  int           exp_rd = 0;
  int           checks = 0;
  int           errors = 0;
  int           pop_n  = 0;
  logic [W-1:0] last_data = '0;
  int           last_len  = 0;
  bit           done = 1'b0;

  // first pops of the directed section, in order
  logic [W-1:0] dir_w [7] = '{12'h8D1, 12'h035, 12'h03B, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
  int           dir_l [7] = '{4, 2, 2, 4, 4, 4, 4};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: digits collected in a queue, words formed by shifting, FIFO as a count.
  initial begin
    logic [W-1:0] w;
    int           len;
    bit           pop, push;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        digs.delete();
        mdl_cnt = 0;
        exp_ovf = 1'b0;
      end else begin
        pop  = (mdl_cnt > 0) && out_ready;
        push = 1'b0;
        w    = '0;
        len  = 0;
        if (in_flag) digs.push_back(int'(in_data));
        if (digs.size() == DIGITS || (flush && digs.size() > 0)) begin
          foreach (digs[i]) w = w | (W'(digs[i]) << (3 * i));
          len  = digs.size();
          digs.delete();
          push = 1'b1;
        end
        if (pop) mdl_cnt--;
        if (push) begin
          if (mdl_cnt < FIFO_DEPTH) begin
            mdl_cnt++;
            exp_data[exp_wr % SB] = w;
            exp_len[exp_wr % SB]  = len;
            exp_wr++;
          end else begin
            exp_ovf = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: samples between edges, compares head against the scoreboard, pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        check("all_words_delivered", 64'(exp_rd), 64'(exp_wr));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
      if (rst) begin
        exp_rd    = exp_wr;
        last_data = '0;
        last_len  = 0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_len", 64'(out_len), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
`ifdef TRI_DIGIT_PACKER_PARITY_EN
        check("rst_out_parity", 64'(out_parity), 64'd0);
`endif
      end else begin
        check("out_valid", 64'(out_valid), 64'(mdl_cnt > 0));
        check("overflow", 64'(overflow), 64'(exp_ovf));
        if (out_valid) begin
          if (exp_rd == exp_wr) begin
            check("unexpected_word", 64'(out_data), 64'hDEAD);
          end else begin
            check("out_data", 64'(out_data), 64'(exp_data[exp_rd % SB]));
            check("out_len", 64'(out_len), 64'(exp_len[exp_rd % SB]));
`ifdef TRI_DIGIT_PACKER_PARITY_EN
            check("out_parity", 64'(out_parity), 64'(^exp_data[exp_rd % SB]));
`endif
            if (out_ready) begin
              if (pop_n < 7) begin
                check("directed_data", 64'(out_data), 64'(dir_w[pop_n]));
                check("directed_len", 64'(out_len), 64'(dir_l[pop_n]));
`ifdef TRI_DIGIT_PACKER_PARITY_EN
                check("directed_parity", 64'(out_parity), 64'(^dir_w[pop_n]));
`endif
              end
              last_data = exp_data[exp_rd % SB];
              last_len  = exp_len[exp_rd % SB];
              exp_rd++;
              pop_n++;
            end
          end
        end else begin
          check("hold_data", 64'(out_data), 64'(last_data));
          check("hold_len", 64'(out_len), 64'(last_len));
`ifdef TRI_DIGIT_PACKER_PARITY_EN
          check("hold_parity", 64'(out_parity), 64'(^last_data));
`endif
        end
      end
    end
  end

  task automatic drive(input bit f, input int d, input bit fl, input bit r);
    @(posedge clk);
    #2;
    in_flag   = f;
    in_data   = d[2:0];
    flush     = fl;
    out_ready = r;
  endtask

  task automatic idle(input int n, input bit r);
    repeat (n) drive(1'b0, 0, 1'b0, r);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    rst     = 1'b1;
    in_flag = 1'b0;
    flush   = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int rdy_pct;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;

    for (int i = 1; i <= 4; i++) drive(1'b1, i, 1'b0, 1'b1);
    idle(3, 1'b1);

    drive(1'b1, 5, 1'b0, 1'b1);
    drive(1'b1, 6, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b1, 1'b1);
    drive(1'b0, 0, 1'b1, 1'b1);
    idle(3, 1'b1);

    drive(1'b1, 3, 1'b0, 1'b1);
    drive(1'b1, 7, 1'b1, 1'b1);
    idle(3, 1'b1);

    repeat (20) drive(1'b1, 7, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(8, 1'b1);

    async_reset();
    for (int i = 0; i < 19; i++) drive(1'b1, i & 7, 1'b0, 1'b0);
    drive(1'b1, 5, 1'b0, 1'b1);
    idle(8, 1'b1);

    for (int i = 0; i < 10; i++) drive(1'b1, (i + 2) % 8, 1'b0, 1'b0);
    async_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, i + 1, 1'b0, 1'b1);
    idle(4, 1'b1);

    rdy_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) rdy_pct = int'($urandom_range(10, 95));
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
      end else begin
        drive($urandom_range(0, 99) < 60, int'($urandom_range(0, 7)),
              $urandom_range(0, 99) < 7, $urandom_range(0, 99) < rdy_pct);
      end
    end

    idle(12, 1'b1);
    done = 1'b1;
  end

endmodule
